// File: rtl/lsu_pkg.sv
// Shared types and helpers for the byte-sequencing load/store unit.
// Size and state encodings, default RAM size, byte-count helper.
package lsu_pkg;

  localparam int LSU_MEM_BYTES = 32;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } sz_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STORE,
    ST_LOAD,
    ST_LOAD_TAIL,
    ST_RESP,
    ST_ERR
  } state_e;

  // Encoding 2'b11 behaves as a word access.
  function automatic sz_e to_size(input logic [1:0] s);
    sz_e r;
    r = (s == 2'b11) ? SZ_W : sz_e'(s);
    return r;
  endfunction

  function automatic logic [2:0] size_bytes(input sz_e s);
    logic [2:0] n;
    unique case (s)
      SZ_B:    n = 3'd1;
      SZ_H:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load data extender: sign or zero extends the assembled
// little-endian load word according to access size.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  sz_e         size,
  input  logic        uns,
  input  logic [31:0] din,
  output logic [31:0] dout
);

  // Extend from bit 7 or 15; word passes straight through.
  always_comb begin
    dout = din;
    unique case (size)
      SZ_B: dout = uns ? {24'd0, din[7:0]}
                       : {{24{din[7]}}, din[7:0]};
      SZ_H: dout = uns ? {16'd0, din[15:0]}
                       : {{16{din[15]}}, din[15:0]};
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/lsu_byte_seq.sv
// Load/store sequencer splitting core accesses into byte RAM cycles.
// Optional LSU_ADDR_CHK_EN adds alignment and range fault checks.
module lsu_byte_seq
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = LSU_MEM_BYTES,
  parameter int AW        = 32
) (
  input  logic          clk,
  input  logic          rst_enm,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [31:0]   mem_rdata
);

  state_e        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          we_q;
  sz_e           sz_q;
  logic          uns_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   data_q;
  logic [31:0]   ext_data;
  logic          accept;
  logic          fault;
  logic          last;
  logic          cap_en;
  logic [1:0]    cap_lane;
  logic          unused_hi;

  assign unused_hi = ^mem_rdata[31:8];

`ifdef LSU_ADDR_CHK_EN
  localparam logic CHK_EN = 1'b1;
  sz_e         req_sz;
  logic [2:0]  req_n;
  logic        misalign;
  logic [AW:0] last_addr;

  assign req_sz    = to_size(req_size);
  assign req_n     = size_bytes(req_sz);
  assign misalign  = (req_sz == SZ_H && req_addr[0]) ||
                     (req_sz == SZ_W && req_addr[1:0] != 2'b00);
  assign last_addr = {1'b0, req_addr} + (AW+1)'(req_n)
                   - (AW+1)'(1);
  assign fault     = misalign ||
                     (last_addr >= (AW+1)'(MEM_BYTES));
`else
  localparam logic CHK_EN = 1'b0;
  logic unused_cfg;
  assign unused_cfg = (MEM_BYTES != 0);
  assign fault      = 1'b0;
`endif

  assign accept = req_valid && req_ready;
  assign last   = ({1'b0, cnt_q} == size_bytes(sz_q) - 3'd1);

  lsu_load_ext u_ext (
    .size (sz_q),
    .uns  (uns_q),
    .din  (data_q),
    .dout (ext_data)
  );

  // State, byte counter, latched request and load byte capture.
  always_ff @(posedge clk) begin
    if (rst_enm) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      we_q    <= 1'b0;
      sz_q    <= SZ_B;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        sz_q    <= to_size(req_size);
        uns_q   <= req_unsigned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        data_q  <= '0;
      end else if (cap_en) begin
        data_q[{cap_lane, 3'b000} +: 8] <= mem_rdata[7:0];
      end
    end
  end

  // Next state plus all port outputs from the current state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    cap_en     = 1'b0;
    cap_lane   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cnt_d = 2'd0;
          if (fault)       state_d = ST_ERR;
          else if (req_we) state_d = ST_STORE;
          else             state_d = ST_LOAD;
        end
      end
      ST_STORE: begin
        mem_wr    = 1'b1;
        mem_addr  = addr_q + AW'(cnt_q);
        mem_wdata = wdata_q[{cnt_q, 3'b000} +: 8];
        if (last) state_d = ST_RESP;
        else      cnt_d   = cnt_q + 2'd1;
      end
      ST_LOAD: begin
        mem_rd   = 1'b1;
        mem_addr = addr_q + AW'(cnt_q);
        cap_en   = (cnt_q != 2'd0);
        cap_lane = cnt_q - 2'd1;
        if (last) state_d = ST_LOAD_TAIL;
        else      cnt_d   = cnt_q + 2'd1;
      end
      ST_LOAD_TAIL: begin
        cap_en   = 1'b1;
        cap_lane = cnt_q;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = we_q ? 32'd0 : ext_data;
        state_d    = ST_IDLE;
      end
      ST_ERR: begin
        resp_valid = 1'b1;
        resp_err   = CHK_EN;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_byte_seq.sv
// Self-checking bench for lsu_byte_seq with a byte RAM model
// and an access-level reference of memory contents and responses.
module tb_lsu_byte_seq;

  logic        clk;
  logic        rst_enm;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [31:0] mem_rdata;

  logic [7:0]  ram  [32];
  logic [7:0]  refm [32];
  logic        ram_init;
  int          checks;
  int          errors;

  lsu_byte_seq dut (
    .clk          (clk),
    .rst_enm      (rst_enm),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte RAM with registered read; upper read bits are junk.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 32; i++) ram[i] <= 8'(i * 37 + 5);
    end else if (mem_wr) begin
      ram[mem_addr[4:0]] <= mem_wdata;
    end
    if (mem_rd) mem_rdata <= {24'($urandom), ram[mem_addr[4:0]]};
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request starting at a negedge in an IDLE cycle (cycle 0);
  // returns at the negedge of the IDLE cycle after the response.
  task automatic run(input logic we, input logic [1:0] sz,
                     input logic uns, input logic [31:0] a,
                     input logic [31:0] wd, input logic hold);
    int          n;
    int          lat;
    logic        flt;
    logic        st;
    logic [31:0] ak;
    logic [31:0] v;
    logic [31:0] exp_rd;
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    flt = 1'b0;
`ifdef LSU_ADDR_CHK_EN
    flt = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00) ||
          ({32'd0, a} + 64'(n) - 64'd1 >= 64'd32);
`endif
    exp_rd = 32'd0;
    if (!flt && we) begin
      for (int k = 0; k < n; k++) begin
        ak = a + 32'(k);
        refm[ak[4:0]] = wd[8*k +: 8];
      end
    end else if (!flt) begin
      v = 32'd0;
      for (int k = 0; k < n; k++) begin
        ak = a + 32'(k);
        v  = v | (32'(refm[ak[4:0]]) << (8 * k));
      end
      if (!uns && n < 4 && v[8*n-1])
        v = v | ~((32'd1 << (8 * n)) - 32'd1);
      exp_rd = v;
    end
    lat = flt ? 1 : (we ? n + 1 : n + 2);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    chk("ready_c0", 32'(req_ready), 32'd1);
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) req_valid = 1'b0;
      st = !flt && (c <= n);
      chk("mem_wr", 32'(mem_wr), 32'(st && we));
      chk("mem_rd", 32'(mem_rd), 32'(st && !we));
      if (st) chk("mem_addr", mem_addr, a + 32'(c - 1));
      if (st && we)
        chk("mem_wdata", 32'(mem_wdata), 32'(wd[8*(c-1) +: 8]));
      chk("resp_valid", 32'(resp_valid), 32'(c == lat));
      if (c == lat) begin
        chk("resp_rdata", resp_rdata, exp_rd);
        chk("resp_err", 32'(resp_err), 32'(flt));
      end
      chk("req_ready", 32'(req_ready), 32'(c == lat + 1));
    end
  endtask

  initial begin
    logic        we;
    logic [1:0]  sz;
    logic [31:0] a;
    checks       = 0;
    errors       = 0;
    rst_enm      = 1'b1;
    ram_init     = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = 32'd0;
    req_wdata    = 32'd0;
    for (int i = 0; i < 32; i++) refm[i] = 8'(i * 37 + 5);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rvalid", 32'(resp_valid), 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_rd", 32'(mem_rd), 32'd0);
    chk("rst_wr", 32'(mem_wr), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    rst_enm  = 1'b0;
    ram_init = 1'b0;
    @(negedge clk);

    run(1'b1, 2'd2, 1'b0, 32'd4, 32'hDEADBEEF, 1'b0);
    run(1'b0, 2'd2, 1'b0, 32'd4, 32'd0, 1'b0);
    run(1'b0, 2'd0, 1'b0, 32'd7, 32'd0, 1'b0);
    run(1'b0, 2'd0, 1'b1, 32'd7, 32'd0, 1'b0);
    run(1'b0, 2'd1, 1'b0, 32'd4, 32'd0, 1'b0);
    run(1'b0, 2'd1, 1'b1, 32'd4, 32'd0, 1'b0);
    chk("lb_ref", {24'd0, refm[7]}, 32'h000000DE);

    run(1'b0, 2'd2, 1'b0, 32'd4, 32'd0, 1'b1);
    run(1'b0, 2'd1, 1'b1, 32'd6, 32'd0, 1'b0);

    req_valid    = 1'b1;
    req_we       = 1'b1;
    req_size     = 2'd2;
    req_unsigned = 1'b0;
    req_addr     = 32'd8;
    req_wdata    = 32'h11223344;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst4_wr1", 32'(mem_wr), 32'd1);
    @(negedge clk);
    chk("rst4_wr2", 32'(mem_wr), 32'd1);
    rst_enm = 1'b1;
    @(negedge clk);
    chk("rst4_wr3", 32'(mem_wr), 32'd0);
    chk("rst4_rv3", 32'(resp_valid), 32'd0);
    rst_enm = 1'b0;
    refm[8] = 8'h44;
    refm[9] = 8'h33;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rst4_ready", 32'(req_ready), 32'd1);
      chk("rst4_rv", 32'(resp_valid), 32'd0);
      chk("rst4_wr", 32'(mem_wr), 32'd0);
    end
    for (int i = 8; i < 12; i++) chk("rst4_ram", 32'(ram[i]), 32'(refm[i]));
    run(1'b0, 2'd2, 1'b1, 32'd8, 32'd0, 1'b0);

    run(1'b0, 2'd2, 1'b0, 32'd6, 32'd0, 1'b0);
    run(1'b1, 2'd1, 1'b0, 32'd31, 32'h0000A55A, 1'b0);
    run(1'b1, 2'd3, 1'b0, 32'hFFFFFFFE, 32'hCAFEF00D, 1'b0);
    run(1'b0, 2'd3, 1'b0, 32'hFFFFFFFE, 32'd0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0)
        a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1 && sz != 2'd0)
        a = a & ((sz == 2'd1) ? 32'hFFFFFFFE : 32'hFFFFFFFC);
      run(we, sz, 1'($urandom_range(0, 1)), a, $urandom,
          (i != 39) && ($urandom_range(0, 3) == 0));
    end

    for (int i = 0; i < 32; i++) chk("ram_final", 32'(ram[i]), 32'(refm[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
